// File: rtl/lfsr_pkg.sv
// Shared constants, checker state encoding and helpers for the 8-bit Galois LFSR family.
package lfsr_pkg;

  localparam int LFSR_LEN = 8;
  localparam logic [8:1] LFSR_TAP_DEFAULT = 8'b1010_0101;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  function automatic logic [3:0] popcount8(input logic [1:LFSR_LEN] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 1; i <= LFSR_LEN; i++) begin
      n = n + {3'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr_next_state.sv
// Combinational one-step advance of the Galois LFSR; shared by generator and checker.
module lfsr_next_state
  import lfsr_pkg::*;
(
  input  logic [1:LFSR_LEN] w_i,
  input  logic [LFSR_LEN:1] taps_i,
  output logic [1:LFSR_LEN] next_o
);

  // Bit 8 falls out of the register and feeds back into every tapped stage.
  always_comb begin
    next_o[1] = w_i[LFSR_LEN];
    for (int i = 2; i <= LFSR_LEN; i++) begin
      next_o[i] = taps_i[LFSR_LEN + 1 - i] ? (w_i[i-1] ^ w_i[LFSR_LEN]) : w_i[i-1];
    end
  end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Receive-side LFSR sequence checker: hunt/verify/lock with saturating error count.
// Build option LFSR_CHK_BITERR_EN: count mismatched bits instead of mismatched words.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter logic [8:1]  Tap_Coefficient = LFSR_TAP_DEFAULT,
  parameter int unsigned LOCK_CNT        = 4,
  parameter int unsigned LOSS_CNT        = 3,
  parameter int unsigned ERR_W           = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [1:8]       in_word,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] LOCK_N = LOCK_CNT[3:0];
  localparam logic [3:0] LOSS_N = LOSS_CNT[3:0];

  chk_state_e       state_q, state_d;
  logic [1:8]       pred_q, pred_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             pulse_q, pulse_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;

  logic [1:8]       step_word_s;
  logic [1:8]       step_pred_s;
  logic             word_eq_s;
  logic             word_zero_s;
  logic             err_add_s;
  logic [3:0]       err_inc_s;
  logic [ERR_W+3:0] sum_s;
  logic [ERR_W+3:0] sat_max_s;

  lfsr_next_state u_step_word (
    .w_i    (in_word),
    .taps_i (Tap_Coefficient),
    .next_o (step_word_s)
  );

  // Flywheel path: once locked, prediction runs from the previous prediction only.
  lfsr_next_state u_step_pred (
    .w_i    (pred_q),
    .taps_i (Tap_Coefficient),
    .next_o (step_pred_s)
  );

  assign word_eq_s   = (in_word == pred_q);
  assign word_zero_s = (in_word == 8'd0);

`ifdef LFSR_CHK_BITERR_EN
  assign err_inc_s = popcount8(in_word ^ pred_q);
`else
  assign err_inc_s = 4'd1;
`endif

  assign sum_s     = {{4{1'b0}}, cnt_q} + {{ERR_W{1'b0}}, err_inc_s};
  assign sat_max_s = {{4{1'b0}}, {ERR_W{1'b1}}};

  // Next-state, prediction, lock counters and registered output values.
  always_comb begin
    state_d   = state_q;
    pred_d    = pred_q;
    match_d   = match_q;
    miss_d    = miss_q;
    pulse_d   = 1'b0;
    err_add_s = 1'b0;
    if (in_valid) begin
      case (state_q)
        HUNT: begin
          if (!word_zero_s) begin
            pred_d  = step_word_s;
            match_d = 4'd0;
            state_d = VERIFY;
          end else begin
            state_d = HUNT;
          end
        end
        VERIFY: begin
          if (word_eq_s) begin
            match_d = match_q + 4'd1;
            pred_d  = step_word_s;
            if ((match_q + 4'd1) == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end else begin
              state_d = VERIFY;
            end
          end else if (!word_zero_s) begin
            pred_d  = step_word_s;
            match_d = 4'd0;
          end else begin
            state_d = HUNT;
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          pred_d = step_pred_s;
          if (word_eq_s) begin
            miss_d = 4'd0;
          end else begin
            pulse_d   = 1'b1;
            err_add_s = 1'b1;
            miss_d    = miss_q + 4'd1;
            if ((miss_q + 4'd1) == LOSS_N) begin
              state_d = HUNT;
              miss_d  = 4'd0;
              match_d = 4'd0;
            end else begin
              state_d = LOCKED;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // Clear has priority over an error arriving on the same cycle.
    if (clear) begin
      cnt_d = {ERR_W{1'b0}};
    end else if (err_add_s) begin
      cnt_d = (sum_s > sat_max_s) ? {ERR_W{1'b1}} : sum_s[ERR_W-1:0];
    end else begin
      cnt_d = cnt_q;
    end

    locked_d = (state_d == LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= HUNT;
      pred_q   <= 8'd0;
      match_q  <= 4'd0;
      miss_q   <= 4'd0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= {ERR_W{1'b0}};
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      cnt_q    <= cnt_d;
    end
  end

  assign locked    = locked_q;
  assign err_pulse = pulse_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Self-checking bench for lfsr_seq_checker: vector table, corner sequences, random vs model.
module tb_lfsr_seq_checker;

`ifdef LFSR_CHK_BITERR_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif
  localparam logic [7:0] TAP = 8'hA5;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [1:8]  in_word;
  logic        clear;
  logic        locked1, pulse1, locked2, pulse2;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  int checks = 0;
  int errors = 0;

  lfsr_seq_checker #(.Tap_Coefficient(8'b1010_0101), .LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(16)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_word(in_word), .clear(clear),
    .locked(locked1), .err_pulse(pulse1), .err_count(cnt1));

  lfsr_seq_checker #(.Tap_Coefficient(8'b1010_0101), .LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(4)) dut2 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_word(in_word), .clear(clear),
    .locked(locked2), .err_pulse(pulse2), .err_count(cnt2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         mode;   // 0 hunt, 1 verify, 2 locked
    logic [7:0] pred;
    int         mc;
    int         xc;
    int         cnt;
    bit         lk;
    bit         pl;
  } mdl_t;

  typedef struct {
    bit         v;
    logic [7:0] w;
    bit         c;
    bit         l;
    bit         p;
    int         cnt;
  } vec_t;

  mdl_t m1, m2;
  vec_t tbl[$];
  logic [7:0] g;

  // Galois shift: LSB (bit 8) leaves, shift right, XOR the tap mask when it was 1.
  function automatic logic [7:0] ref_step(logic [7:0] w);
    return (w >> 1) ^ (w[0] ? ((TAP & 8'h7F) | 8'h80) : 8'h00);
  endfunction

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.mode = 0; m.pred = 8'h00; m.mc = 0; m.xc = 0; m.cnt = 0; m.lk = 1'b0; m.pl = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int lock_n, int loss_n, int errw,
                                    bit v, logic [7:0] w, bit c);
    int add;
    int maxv;
    maxv = (1 << errw) - 1;
    add  = 0;
    m.pl = 1'b0;
    if (v) begin
      if (m.mode == 0) begin
        if (w != 8'h00) begin m.pred = ref_step(w); m.mc = 0; m.mode = 1; end
      end else if (m.mode == 1) begin
        if (w == m.pred) begin
          m.mc++;
          m.pred = ref_step(w);
          if (m.mc == lock_n) begin m.mode = 2; m.xc = 0; end
        end else if (w != 8'h00) begin
          m.pred = ref_step(w); m.mc = 0;
        end else begin
          m.mode = 0;
        end
      end else begin
        if (w != m.pred) begin
          m.pl = 1'b1;
          add  = BE ? $countones(w ^ m.pred) : 1;
          m.xc++;
          if (m.xc == loss_n) m.mode = 0;
        end else begin
          m.xc = 0;
        end
        m.pred = ref_step(m.pred);
        m.cnt  = (m.cnt + add > maxv) ? maxv : m.cnt + add;
      end
    end
    if (c) m.cnt = 0;
    m.lk = (m.mode == 2);
    return m;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(bit v, logic [7:0] w, bit c);
    in_valid = v;
    in_word  = w;
    clear    = c;
    @(posedge clock);
    m1 = mdl_step(m1, 4, 3, 16, v, w, c);
    m2 = mdl_step(m2, 4, 15, 4, v, w, c);
    #1;
    chk("locked1", locked1, m1.lk);
    chk("pulse1", pulse1, m1.pl);
    chk("count1", cnt1, m1.cnt);
    chk("locked2", locked2, m2.lk);
    chk("pulse2", pulse2, m2.pl);
    chk("count2", cnt2, m2.cnt);
  endtask

  // Reset is asserted between clock edges and checked before any edge arrives.
  task automatic do_reset();
    #3;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    clear    = 1'b0;
    m1 = mdl_rst();
    m2 = mdl_rst();
    #1;
    chk("rst_locked1", locked1, 0);
    chk("rst_pulse1", pulse1, 0);
    chk("rst_count1", cnt1, 0);
    chk("rst_locked2", locked2, 0);
    chk("rst_pulse2", pulse2, 0);
    chk("rst_count2", cnt2, 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic add_vec(bit v, logic [7:0] w, bit c, bit l, bit p, int cnt);
    vec_t e;
    e.v = v; e.w = w; e.c = c; e.l = l; e.p = p; e.cnt = cnt;
    tbl.push_back(e);
  endtask

  // Generator word, then advance the generator.
  task automatic gen_vec(logic [7:0] mask, bit c, bit l, bit p, int cnt);
    add_vec(1'b1, g ^ mask, c, l, p, cnt);
    g = ref_step(g);
  endtask

  task automatic feed_clean(int n);
    for (int i = 0; i < n; i++) begin
      apply(1'b1, g, 1'b0);
      g = ref_step(g);
    end
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_word  = 8'h00;
    clear    = 1'b0;
    m1 = mdl_rst();
    m2 = mdl_rst();

    // ---- table: acquisition, single/double errors, clear, loss with gaps, relock ----
    g = 8'h80;
    add_vec(1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 0);
    add_vec(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 0);
    gen_vec(8'h00, 1'b0, 1'b0, 1'b0, 0);            // seed 1000_0000
    add_vec(1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 0);
    gen_vec(8'h00, 1'b0, 1'b0, 1'b0, 0);
    gen_vec(8'h00, 1'b0, 1'b0, 1'b0, 0);
    gen_vec(8'h00, 1'b0, 1'b0, 1'b0, 0);
    gen_vec(8'h00, 1'b0, 1'b1, 1'b0, 0);            // 5th word: lock
    gen_vec(8'h00, 1'b0, 1'b1, 1'b0, 0);
    gen_vec(8'h20, 1'b0, 1'b1, 1'b1, 1);            // bit 3 flipped
    gen_vec(8'h00, 1'b0, 1'b1, 1'b0, 1);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    gen_vec(8'h81, 1'b0, 1'b1, 1'b1, BE ? 3 : 2);   // two bits flipped
    gen_vec(8'h01, 1'b1, 1'b1, 1'b1, 0);            // clear wins over error
    gen_vec(8'h00, 1'b0, 1'b1, 1'b0, 0);
    gen_vec(8'h01, 1'b0, 1'b1, 1'b1, 1);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1);
    gen_vec(8'h01, 1'b0, 1'b1, 1'b1, 2);
    add_vec(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2);
    gen_vec(8'h03, 1'b0, 1'b0, 1'b1, BE ? 4 : 3);   // 3rd miss drops lock
    gen_vec(8'h00, 1'b0, 1'b0, 1'b0, BE ? 4 : 3);   // reseed
    gen_vec(8'h00, 1'b0, 1'b0, 1'b0, BE ? 4 : 3);
    gen_vec(8'h00, 1'b0, 1'b0, 1'b0, BE ? 4 : 3);
    gen_vec(8'h00, 1'b0, 1'b0, 1'b0, BE ? 4 : 3);
    gen_vec(8'h00, 1'b0, 1'b1, 1'b0, BE ? 4 : 3);   // relocked

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].v, tbl[i].w, tbl[i].c);
      chk($sformatf("tbl%0d_locked", i), locked1, tbl[i].l);
      chk($sformatf("tbl%0d_pulse", i), pulse1, tbl[i].p);
      chk($sformatf("tbl%0d_count", i), cnt1, tbl[i].cnt);
    end

    // ---- feedback step inside VERIFY: 0000_0001 then 1010_0101 is a match ----
    do_reset();
    apply(1'b1, 8'h01, 1'b0);
    apply(1'b1, 8'hA5, 1'b0);
    g = ref_step(8'hA5);
    feed_clean(2);
    chk("fb_not_yet_locked", locked1, 0);
    feed_clean(1);
    chk("fb_locked", locked1, 1);

    // ---- all-zero stream stays in HUNT ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 8'h00, 1'b0);
      chk("zero_hunt", locked1, 0);
    end

    // ---- saturation on the 4-bit counter; no loss thanks to alternating clean words ----
    do_reset();
    g = 8'h80;
    feed_clean(5);
    for (int k = 0; k < 20; k++) begin
      apply(1'b1, g ^ (8'h01 << (k % 8)), 1'b0);
      g = ref_step(g);
      feed_clean(1);
    end
    chk("sat_count2", cnt2, 15);
    chk("sat_locked2", locked2, 1);
    chk("sat_count1", cnt1, 20);
    apply(1'b1, g, 1'b1);
    g = ref_step(g);
    chk("sat_clear2", cnt2, 0);
    chk("sat_clear_locked2", locked2, 1);

    // ---- asynchronous reset while locked with err_count = 7 ----
    feed_clean(1);
    for (int k = 0; k < 7; k++) begin
      apply(1'b1, g ^ 8'h04, 1'b0);
      g = ref_step(g);
      feed_clean(1);
    end
    chk("pre_rst_count", cnt1, 7);
    chk("pre_rst_locked", locked1, 1);
    do_reset();
    feed_clean(1);
    chk("post_rst_needs_relock", locked1, 0);
    feed_clean(3);
    chk("post_rst_still_verify", locked1, 0);
    feed_clean(1);
    chk("post_rst_relocked", locked1, 1);

    // ---- randomized traffic against the reference model ----
    do_reset();
    g = 8'($urandom_range(1, 255));
    for (int n = 0; n < 1500; n++) begin
      bit         v;
      bit         c;
      int         kind;
      logic [7:0] w;
      v    = ($urandom_range(0, 99) >= 12);
      c    = ($urandom_range(0, 99) < 3);
      kind = $urandom_range(0, 99);
      if (kind < 8)       w = g ^ 8'($urandom_range(1, 255));
      else if (kind < 11) w = 8'h00;
      else if (kind < 13) w = 8'($urandom_range(0, 255));
      else                w = g;
      apply(v, w, c);
      if (v) g = ref_step(g);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
